// File: rtl/multiply_add_seq_ctrl.sv
// Job sequencer for a digit-serial multiply-add datapath: latches a job, streams WIDTH operand digits
// plus DELTA zero flush digits, and collects result digits. Optional MULTIPLY_ADD_SEQ_PERF_EN adds job_count.
module multiply_add_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int M     = 8,
    parameter int DELTA = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [M-1:0]         in_a,
    input  logic [3*WIDTH-1:0]   in_x,
    input  logic [3*WIDTH-1:0]   in_c,
    output logic                 dp_start,
    output logic                 dp_en,
    output logic [M-1:0]         dp_a,
    output logic [2:0]           dp_x_digit,
    output logic [2:0]           dp_c_digit,
    input  logic [2:0]           dp_y_digit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3*WIDTH-1:0]   out_y
`ifdef MULTIPLY_ADD_SEQ_PERF_EN
    ,
    output logic [15:0]          job_count
`endif
);

    localparam int STEPS = WIDTH + DELTA;
    localparam int KW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [KW-1:0]      r_k;
    logic [M-1:0]       r_a;
    logic [3*WIDTH-1:0] r_x;
    logic [3*WIDTH-1:0] r_c;
    logic [3*WIDTH-1:0] r_y;

    logic w_accept;
    logic w_feed;
    logic w_last;
    logic w_release;

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_feed    = (r_state == S_FEED);
    assign w_last    = (r_k == KW'(STEPS - 1));
    assign w_release = (r_state == S_DONE) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next = S_FEED;
            S_FEED:  if (w_last)    w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    // Result digit for input step j arrives DELTA steps later, so step k fills digit k-DELTA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k <= '0;
            r_a <= '0;
            r_x <= '0;
            r_c <= '0;
            r_y <= '0;
        end else if (w_accept) begin
            r_k <= '0;
            r_a <= in_a;
            r_x <= in_x;
            r_c <= in_c;
            r_y <= '0;
        end else if (w_feed) begin
            if (!w_last) begin
                r_k <= r_k + KW'(1);
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (r_k == KW'(i + DELTA)) begin
                    r_y[3*i +: 3] <= dp_y_digit;
                end
            end
        end
    end

    always_comb begin
        in_ready   = (r_state == S_IDLE);
        out_valid  = (r_state == S_DONE);
        dp_en      = w_feed;
        dp_start   = w_feed && (r_k == '0);
        dp_x_digit = 3'b000;
        dp_c_digit = 3'b000;
        if (w_feed) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_k == KW'(i)) begin
                    dp_x_digit = r_x[3*i +: 3];
                    dp_c_digit = r_c[3*i +: 3];
                end
            end
        end
    end

    assign dp_a  = r_a;
    assign out_y = r_y;

`ifdef MULTIPLY_ADD_SEQ_PERF_EN
    logic [15:0] r_job_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_job_count <= '0;
        end else if (w_release) begin
            r_job_count <= r_job_count + 16'd1;
        end
    end

    assign job_count = r_job_count;
`endif

endmodule

// File: tb/tb_multiply_add_seq_ctrl.sv
// Directed bench for multiply_add_seq_ctrl with a datapath model that echoes x digits after DELTA steps.
// Build with MULTIPLY_ADD_SEQ_PERF_EN defined to also check job_count.
module tb_multiply_add_seq_ctrl;

    localparam int WIDTH = 32;
    localparam int M     = 8;
    localparam int DELTA = 2;
    localparam int STEPS = WIDTH + DELTA;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [M-1:0]         in_a = '0;
    logic [3*WIDTH-1:0]   in_x = '0;
    logic [3*WIDTH-1:0]   in_c = '0;
    logic                 dp_start;
    logic                 dp_en;
    logic [M-1:0]         dp_a;
    logic [2:0]           dp_x_digit;
    logic [2:0]           dp_c_digit;
    logic [2:0]           dp_y_digit;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [3*WIDTH-1:0]   out_y;
`ifdef MULTIPLY_ADD_SEQ_PERF_EN
    logic [15:0]          job_count;
`endif

    multiply_add_seq_ctrl #(.WIDTH(WIDTH), .M(M), .DELTA(DELTA)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_x       (in_x),
        .in_c       (in_c),
        .dp_start   (dp_start),
        .dp_en      (dp_en),
        .dp_a       (dp_a),
        .dp_x_digit (dp_x_digit),
        .dp_c_digit (dp_c_digit),
        .dp_y_digit (dp_y_digit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y)
`ifdef MULTIPLY_ADD_SEQ_PERF_EN
        ,
        .job_count  (job_count)
`endif
    );

    always #5 clk = ~clk;

    // Datapath stand-in: two-step delay line on the x digit, advanced only on dp_en.
    logic [2:0] r_p0, r_p1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p0 <= 3'b000;
            r_p1 <= 3'b000;
        end else if (dp_en) begin
            r_p0 <= dp_x_digit;
            r_p1 <= r_p0;
        end
    end
    assign dp_y_digit = r_p1;

    typedef struct {
        logic [M-1:0]       a;
        logic [3*WIDTH-1:0] x;
        logic [3*WIDTH-1:0] c;
        logic [3*WIDTH-1:0] y;
        int                 hold;
    } vec_t;

    vec_t vecs[3];
    int   checks = 0;
    int   errors = 0;
    int   jobs_exp = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, ".in_ready"},  in_ready,  1);
        check({tag, ".out_valid"}, out_valid, 0);
        check({tag, ".dp_en"},     dp_en,     0);
        check({tag, ".dp_start"},  dp_start,  0);
        check({tag, ".dp_a"},      dp_a,      0);
        check({tag, ".dp_digits"}, {dp_x_digit, dp_c_digit}, 0);
        check({tag, ".out_y"},     out_y,     0);
`ifdef MULTIPLY_ADD_SEQ_PERF_EN
        check({tag, ".job_count"}, job_count, 0);
`endif
    endtask

    task automatic run_job(input vec_t v, input string tag);
        int n, en_cnt, st_cnt, dig_err, hold_err;
        logic [3*WIDTH-1:0] y_snap;
        @(negedge clk);
        check({tag, ".in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_a = v.a;
        in_x = v.x;
        in_c = v.c;
        @(negedge clk);
        // Scramble inputs after accept: the controller must use its latched copy.
        in_valid = 1'b0;
        in_a = ~v.a;
        in_x = ~v.x;
        in_c = ~v.c;
        n = 1; en_cnt = 0; st_cnt = 0; dig_err = 0;
        while (!out_valid && n < 3*STEPS) begin
            if (dp_en) begin
                if (dp_x_digit !== ((en_cnt < WIDTH) ? v.x[3*en_cnt +: 3] : 3'b000)) dig_err++;
                if (dp_c_digit !== ((en_cnt < WIDTH) ? v.c[3*en_cnt +: 3] : 3'b000)) dig_err++;
                en_cnt++;
            end
            if (dp_start) st_cnt++;
            in_valid = (n % 7 == 3);
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check({tag, ".latency"},  n,       STEPS + 1);
        check({tag, ".en_count"}, en_cnt,  STEPS);
        check({tag, ".starts"},   st_cnt,  1);
        check({tag, ".digits"},   dig_err, 0);
        check({tag, ".out_y"},    out_y,   v.y);
        check({tag, ".dp_a"},     dp_a,    v.a);
        y_snap = out_y;
        hold_err = 0;
        for (int i = 0; i < v.hold; i++) begin
            in_valid = i[0];
            @(negedge clk);
            if (out_valid !== 1'b1 || out_y !== y_snap || in_ready !== 1'b0 || dp_en !== 1'b0)
                hold_err++;
        end
        in_valid = 1'b0;
        if (v.hold > 0) check({tag, ".hold_stable"}, hold_err, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        jobs_exp++;
        check({tag, ".released_valid"}, out_valid, 0);
        check({tag, ".released_ready"}, in_ready,  1);
        check({tag, ".dp_a_held"},      dp_a,      v.a);
`ifdef MULTIPLY_ADD_SEQ_PERF_EN
        check({tag, ".job_count"}, job_count, jobs_exp);
`endif
    endtask

    initial begin
        int n, m, spur;

        vecs[0].a = 8'h30; vecs[0].hold = 0;
        vecs[1].a = 8'hA5; vecs[1].hold = 10;
        vecs[2].a = 8'hFF; vecs[2].hold = 3;
        for (int i = 0; i < WIDTH; i++) begin
            vecs[0].x[3*i +: 3] = 3'b001;
            vecs[0].c[3*i +: 3] = 3'b001;
            vecs[0].y[3*i +: 3] = 3'b001;
            vecs[1].x[3*i +: 3] = 3'(i % 4);
            vecs[1].c[3*i +: 3] = 3'(3 - (i % 4));
            vecs[1].y[3*i +: 3] = 3'(i % 4);
            vecs[2].x[3*i +: 3] = (i % 2 == 0) ? 3'b111 : 3'b101;
            vecs[2].c[3*i +: 3] = 3'b110;
            vecs[2].y[3*i +: 3] = (i % 2 == 0) ? 3'b111 : 3'b101;
        end

        repeat (2) @(negedge clk);
        check_reset_outs("reset");
        rst_n = 1'b1;

        for (int v = 0; v < 3; v++) run_job(vecs[v], $sformatf("vec%0d", v));

        // Reset asserted in the middle of FEED at step k=15.
        @(negedge clk);
        in_valid = 1'b1; in_a = vecs[2].a; in_x = vecs[2].x; in_c = vecs[2].c;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("midrst.in_feed", dp_en, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outs("midrst");
        jobs_exp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        spur = 0;
        repeat (2*STEPS) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || dp_en !== 1'b0) spur++;
        end
        check("midrst.quiet", spur, 0);
        run_job(vecs[1], "after_rst");

        // Back-to-back: in_valid and out_ready held high for two jobs.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = vecs[0].a; in_x = vecs[0].x; in_c = vecs[0].c;
        n = 0;
        while (!out_valid && n < 3*STEPS) begin
            @(negedge clk);
            n++;
        end
        check("b2b.first_latency", n, STEPS + 1);
        check("b2b.first_y", out_y, vecs[0].y);
        @(negedge clk);
        check("b2b.idle_ready", in_ready, 1);
        check("b2b.idle_valid", out_valid, 0);
        @(negedge clk);
        check("b2b.second_start", dp_start, 1);
        m = 2;
        while (!out_valid && m < 3*STEPS) begin
            @(negedge clk);
            m++;
        end
        in_valid = 1'b0;
        check("b2b.period", m, STEPS + 2);
        check("b2b.second_y", out_y, vecs[0].y);
        @(negedge clk);
        out_ready = 1'b0;
        jobs_exp += 2;
        check("b2b.final_idle", in_ready, 1);
`ifdef MULTIPLY_ADD_SEQ_PERF_EN
        check("b2b.job_count", job_count, jobs_exp);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiply_add_seq_ctrl.md
MULTIPLY_ADD_SEQ_CTRL -- requirements
Module: multiply_add_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: digits per operand/result; radix-4 signed digits, 3-bit two's complement each.
REQ-002 Parameter M, default 8: width of scalar coefficient a.
REQ-003 Parameter DELTA, default 2: online delay of the attached digit-serial multiply-add unit, in cycles; legal range 1..WIDTH-1.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  job request.
REQ-007 in_ready  out  1  controller accepts a job this cycle.
REQ-008 in_a  in  M  coefficient a.
REQ-009 in_x  in  3*WIDTH  operand x; digit i at bits [3i+2:3i], digit 0 most significant (weight 4^-i).
REQ-010 in_c  in  3*WIDTH  operand c; same packing as in_x.
REQ-011 dp_start  out  1  first-digit strobe to datapath.
REQ-012 dp_en  out  1  datapath digit step enable.
REQ-013 dp_a  out  M  coefficient held for whole job.
REQ-014 dp_x_digit, dp_c_digit  out  3 each  current input digits.
REQ-015 dp_y_digit  in  3  result digit from datapath, valid DELTA steps after its inputs.
REQ-016 out_valid  out  1  result available.
REQ-017 out_ready  in  1  consumer takes result.
REQ-018 out_y  out  3*WIDTH  result y; same packing as in_x.

Function
REQ-019 FSM states IDLE, FEED, DONE; in_ready=1 only in IDLE.
REQ-020 IDLE: in_valid=1 -> latch in_a/in_x/in_c, clear out_y, step counter k=0, go FEED next cycle.
REQ-021 FEED: dp_en=1 each cycle; dp_start=1 only when k=0.
REQ-022 FEED digit drive: k<WIDTH -> x[k], c[k]; WIDTH<=k<WIDTH+DELTA -> 3'b000 (flush).
REQ-023 FEED capture: k>=DELTA -> out_y digit (k-DELTA) <= dp_y_digit.
REQ-024 FEED exit: k=WIDTH+DELTA-1 -> go DONE; FEED lasts exactly WIDTH+DELTA cycles.
REQ-025 Latency: accept at edge T -> out_valid high from cycle T+1+WIDTH+DELTA.
REQ-026 DONE: out_valid=1, out_y stable; out_ready=1 -> IDLE next cycle, out_valid drops same edge.
REQ-027 Back-to-back: new job accepted no earlier than the cycle after DONE exits; minimum job period WIDTH+DELTA+2 cycles.
REQ-028 in_valid during FEED/DONE ignored, no state change; input buses may change freely outside IDLE.
REQ-029 Outside FEED: dp_en=0, dp_start=0, dp digits=3'b000; dp_a holds last latched value.
REQ-030 Counter sized ceil(log2(WIDTH+DELTA)) bits; never wraps within a job.

Reset
REQ-031 rst_n low (any state, incl. mid-FEED): state=IDLE, k=0, out_y=0, dp_a=0, operand registers=0; all outputs 0 except in_ready=1.
REQ-032 Job in flight at reset is discarded; no partial out_valid after release.
REQ-033 First job accepted on first rising edge with rst_n high and in_valid high.

Configuration
REQ-034 Macro MULTIPLY_ADD_SEQ_PERF_EN defined: extra output job_count (16 bits), increments on each DONE->IDLE handshake, wraps 0xFFFF->0, reset 0.
REQ-035 Macro undefined: port job_count and its logic absent; all other behaviour identical.

Verification (WIDTH=32, M=8, DELTA=2; datapath model echoes x digit with 2-step delay)
REQ-036 Reset then accept x=all 001, c=all 001, a=0x30 -> dp_start one cycle, 34 dp_en cycles, out_valid at T+35, out_y=all 001.
REQ-037 x digit i = i mod 4 (signed) -> out_y digit i equals x digit i for all 32 digits; flush digits 32,33 driven 000.
REQ-038 out_ready held low 10 cycles in DONE -> out_valid and out_y stable; in_ready=0; in_valid pulses ignored.
REQ-039 rst_n asserted at FEED step k=15 -> all outputs to reset values same cycle; next job completes correctly.
REQ-040 Two jobs, in_valid held high, out_ready high -> second accept exactly 1 cycle after first out_valid; job_count=2 with MULTIPLY_ADD_SEQ_PERF_EN defined.
